// File: rtl/snn_pkg.sv
// Shared defaults and decoder state type for the spike-rate decoder.
package snn_pkg;

    localparam int unsigned N_CH_DEF  = 8;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned WIN_W_DEF = 8;

    typedef enum logic [0:0] {
        StIdle,
        StCount
    } dec_state_e;

    // Index width that stays legal for a single channel.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_counter.sv
// Saturating spike counter with synchronous clear; exposes the value after
// this cycle's increment so the decoder can build a result from the last sample.
module spike_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count_nxt,
    output logic             sat
);

    logic [CNT_W-1:0] count_q;

    assign sat       = &count_q;
    assign count_nxt = (inc && !sat) ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per channel over a programmable window and hands out the
// counts plus the winning channel through a valid/ready holding register.
import snn_pkg::*;

module spike_rate_decoder #(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned WIN_W = WIN_W_DEF,
    localparam int unsigned IDX_W = idx_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WIN_W-1:0]      window,
    input  logic [N_CH-1:0]       spike_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*CNT_W-1:0] counts,
    output logic [IDX_W-1:0]      winner,
    output logic                  winner_valid,
    output logic                  sat,
    output logic                  overrun
);

    dec_state_e state_q, state_d;
    logic [WIN_W-1:0] win_q, win_eff, idx_q, idx_d;
    logic             restart_q, sat_win_q;
    logic             sampling, done, clr;
    logic [N_CH-1:0]  inc, at_max, ovf;
    logic [CNT_W-1:0] cnt_nxt [N_CH];

    logic [N_CH*CNT_W-1:0] res_counts;
    logic [IDX_W-1:0]      res_winner;
    logic [CNT_W-1:0]      max_cnt;
    logic                  res_wv, res_sat, load;

    logic                  out_valid_q, winner_valid_q, sat_q, overrun_q;
    logic [N_CH*CNT_W-1:0] counts_q;
    logic [IDX_W-1:0]      winner_q;

    // The first sample of a back-to-back window uses the live window input,
    // which is latched in the same cycle.
    assign win_eff = restart_q ? window : win_q;

    always_comb begin
        state_d  = state_q;
        sampling = 1'b0;
        done     = 1'b0;
        clr      = 1'b0;
        unique case (state_q)
            StIdle: begin
                clr = 1'b1;
                if (en) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                if (!en) begin
                    clr     = 1'b1;
                    state_d = StIdle;
                end else begin
                    sampling = 1'b1;
                    if (idx_q == win_eff - WIN_W'(1)) begin
                        done = 1'b1;
                        clr  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        idx_d = (sampling && !done) ? idx_q + WIN_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            win_q     <= '0;
            idx_q     <= '0;
            restart_q <= 1'b0;
            sat_win_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            restart_q <= done;
            sat_win_q <= clr ? 1'b0 : (sat_win_q | (|ovf));
            if (state_q == StIdle || restart_q) begin
                win_q <= window;
            end
        end
    end

    assign inc = spike_in & {N_CH{sampling}};
    assign ovf = inc & at_max;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        spike_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .inc       (inc[g]),
            .count_nxt (cnt_nxt[g]),
            .sat       (at_max[g])
        );
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        res_counts = '0;
        res_winner = '0;
        max_cnt    = cnt_nxt[0];
        for (int i = 0; i < int'(N_CH); i++) begin
            res_counts[i*CNT_W +: CNT_W] = cnt_nxt[i];
        end
        for (int i = 1; i < int'(N_CH); i++) begin
            if (cnt_nxt[i] > max_cnt) begin
                max_cnt    = cnt_nxt[i];
                res_winner = IDX_W'(i);
            end
        end
        res_wv  = |max_cnt;
        res_sat = sat_win_q | (|ovf);
    end

    assign load = done && !(out_valid_q && !out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            counts_q       <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            sat_q          <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            if (load) begin
                out_valid_q    <= 1'b1;
                counts_q       <= res_counts;
                winner_q       <= res_winner;
                winner_valid_q <= res_wv;
                sat_q          <= res_sat;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (done && out_valid_q && !out_ready) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign counts       = counts_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;
    assign sat          = sat_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: window-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spike_rate_decoder;

    localparam int NCH  = 8;
    localparam int CMAX = 255;

    logic        clk;
    logic        rst, en, out_ready;
    logic [7:0]  window, spike_in;
    logic        out_valid, winner_valid, sat, overrun;
    logic [63:0] counts;
    logic [2:0]  winner;

    int checks = 0;
    int errors = 0;

    spike_rate_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .window       (window),
        .spike_in     (spike_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .counts       (counts),
        .winner       (winner),
        .winner_valid (winner_valid),
        .sat          (sat),
        .overrun      (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks a window as a sample count and int counters.
    bit          live = 0;
    bit          m_run = 0, m_fresh = 0, m_ovf = 0;
    int          m_len = 0, m_n = 0;
    int          m_cnt [NCH];
    int          rc [NCH];
    bit          m_done, r_sat;
    bit          mv = 0, mwv = 0, msat = 0, movr = 0;
    int          mwin = 0;
    logic [63:0] mcounts = '0;

    function automatic int win_len(input logic [7:0] w);
        return (w == 0) ? 256 : int'(w);
    endfunction

    always @(posedge clk) begin
        live   = 1;
        m_done = 0;
        if (rst) begin
            m_run = 0; m_fresh = 0; m_n = 0; m_ovf = 0;
            mv = 0; mwv = 0; msat = 0; movr = 0; mwin = 0; mcounts = '0;
        end else begin
            if (!m_run) begin
                if (en) begin
                    m_run = 1; m_len = win_len(window); m_n = 0; m_ovf = 0; m_fresh = 0;
                    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
                end
            end else if (!en) begin
                m_run = 0;
            end else begin
                if (m_fresh) m_len = win_len(window);
                m_fresh = 0;
                for (int i = 0; i < NCH; i++) begin
                    if (spike_in[i]) begin
                        if (m_cnt[i] == CMAX) m_ovf = 1;
                        else m_cnt[i]++;
                    end
                end
                m_n++;
                if (m_n == m_len) begin
                    m_done = 1; r_sat = m_ovf;
                    for (int i = 0; i < NCH; i++) begin
                        rc[i] = m_cnt[i]; m_cnt[i] = 0;
                    end
                    m_ovf = 0; m_n = 0; m_fresh = 1;
                end
            end
            if (m_done) begin
                if (mv && !out_ready) begin
                    movr = 1;
                end else begin
                    int best;
                    best = 0;
                    for (int i = 0; i < NCH; i++) begin
                        mcounts[i*8 +: 8] = 8'(rc[i]);
                        if (rc[i] > rc[best]) best = i;
                    end
                    mv = 1; mwin = best; mwv = (rc[best] != 0); msat = r_sat;
                end
            end else if (out_ready) begin
                mv = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("out_valid", 64'(out_valid), 64'(mv));
            chk("overrun", 64'(overrun), 64'(movr));
            chk("counts", counts, mcounts);
            chk("winner", 64'(winner), 64'(mwin));
            chk("winner_valid", 64'(winner_valid), 64'(mwv));
            chk("sat", 64'(sat), 64'(msat));
        end
    end

    task automatic cyc(input logic e, input logic [7:0] w, input logic [7:0] s, input logic r);
        @(negedge clk);
        en = e; window = w; spike_in = s; out_ready = r;
    endtask

    task automatic release_result();
        cyc(0, 8'd0, 8'h00, 1'b1);
        cyc(0, 8'd0, 8'h00, 1'b0);
        chk("released", 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; window = '0; spike_in = '0;
        repeat (2) cyc(0, 8'd0, 8'h00, 1'b0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_counts", counts, 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        rst = 1'b0;

        // Single channel, 4-cycle window.
        cyc(1, 8'd4, 8'h00, 1'b0);
        repeat (4) cyc(1, 8'd4, 8'h01, 1'b0);
        chk("w4_not_early", 64'(out_valid), 64'd0);
        cyc(0, 8'd0, 8'h00, 1'b0);
        chk("w4_valid", 64'(out_valid), 64'd1);
        chk("w4_counts", counts, 64'h04);
        chk("w4_winner", 64'(winner), 64'd0);
        chk("w4_wv", 64'(winner_valid), 64'd1);
        release_result();

        // Full 256-cycle window, all channels saturate.
        cyc(1, 8'd0, 8'h00, 1'b0);
        repeat (256) cyc(1, 8'd0, 8'hFF, 1'b0);
        cyc(0, 8'd0, 8'h00, 1'b0);
        chk("w256_counts", counts, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w256_sat", 64'(sat), 64'd1);
        chk("w256_winner", 64'(winner), 64'd0);
        release_result();

        // Tie between ch3 and ch6.
        cyc(1, 8'd5, 8'h00, 1'b0);
        cyc(1, 8'd5, 8'h4A, 1'b0);
        cyc(1, 8'd5, 8'h48, 1'b0);
        cyc(1, 8'd5, 8'h48, 1'b0);
        cyc(1, 8'd5, 8'h00, 1'b0);
        cyc(1, 8'd5, 8'h00, 1'b0);
        cyc(0, 8'd0, 8'h00, 1'b0);
        chk("tie_counts", counts, 64'h0003_0000_0300_0100);
        chk("tie_winner", 64'(winner), 64'd3);
        release_result();

        // Back-to-back windows with the consumer stalled.
        cyc(1, 8'd2, 8'h00, 1'b0);
        cyc(1, 8'd2, 8'h01, 1'b0);
        cyc(1, 8'd2, 8'h01, 1'b0);
        cyc(1, 8'd2, 8'h02, 1'b0);
        chk("ovr_first_valid", 64'(out_valid), 64'd1);
        cyc(1, 8'd2, 8'h02, 1'b0);
        cyc(0, 8'd0, 8'h00, 1'b0);
        chk("ovr_held_counts", counts, 64'h02);
        chk("ovr_flag", 64'(overrun), 64'd1);
        release_result();
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Abort on sample 5, then a fresh window.
        cyc(1, 8'd8, 8'h00, 1'b0);
        repeat (4) cyc(1, 8'd8, 8'hFF, 1'b0);
        cyc(0, 8'd8, 8'hFF, 1'b0);
        repeat (10) begin
            cyc(0, 8'd8, 8'h00, 1'b0);
            chk("abort_no_valid", 64'(out_valid), 64'd0);
        end
        cyc(1, 8'd3, 8'h00, 1'b0);
        repeat (3) cyc(1, 8'd3, 8'h04, 1'b0);
        cyc(0, 8'd0, 8'h00, 1'b0);
        chk("fresh_counts", counts, 64'h0000_0000_0003_0000);
        release_result();

        // Reset mid-window with a result pending.
        cyc(1, 8'd4, 8'h00, 1'b0);
        repeat (4) cyc(1, 8'd4, 8'h10, 1'b0);
        cyc(1, 8'd4, 8'h20, 1'b0);
        chk("rst_pending", 64'(out_valid), 64'd1);
        cyc(1, 8'd4, 8'h20, 1'b0);
        cyc(1, 8'd4, 8'h20, 1'b0);
        rst = 1'b1;
        cyc(0, 8'd0, 8'h00, 1'b0);
        rst = 1'b0;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_counts", counts, 64'd0);
        chk("rst_mid_winner", 64'(winner), 64'd0);
        chk("rst_mid_wv", 64'(winner_valid), 64'd0);
        chk("rst_mid_overrun", 64'(overrun), 64'd0);
        repeat (6) begin
            cyc(0, 8'd0, 8'h00, 1'b0);
            chk("rst_no_result", 64'(out_valid), 64'd0);
        end

        // Random traffic with short windows, stalls, aborts and resets.
        repeat (4000) begin
            logic [7:0] w;
            w = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
            rst = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 15) != 0, w, 8'($urandom), $urandom_range(0, 2) != 0);
        end
        rst = 1'b0;

        // Long dense windows to exercise saturation under random stalls.
        repeat (800) begin
            cyc(1, 8'd0, 8'($urandom) | 8'($urandom), $urandom_range(0, 3) != 0);
        end
        cyc(0, 8'd0, 8'h00, 1'b1);
        cyc(0, 8'd0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter N_CH, default 8, number of spike input channels.
REQ-002 Parameter CNT_W, default 8, per-channel count width.
REQ-003 Parameter WIN_W, default 8, window-length field width.
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 en  input  1  1 = decode windows run back-to-back; 0 = idle, any partial window is aborted.
REQ-007 window  input  WIN_W  window length in cycles; 0 SHALL mean 2^WIN_W cycles; sampled only at window start.
REQ-008 spike_in  input  N_CH  one spike bit per channel, sampled every cycle in COUNT.
REQ-009 out_valid  output  1  a result is held on counts/winner/winner_valid/sat.
REQ-010 out_ready  input  1  consumer accepts the result when out_valid and out_ready are both 1.
REQ-011 counts  output  N_CH*CNT_W  per-channel spike counts; channel i at bits [i*CNT_W +: CNT_W].
REQ-012 winner  output  clog2(N_CH)  index of the channel with the highest count.
REQ-013 winner_valid  output  1  0 when every count in the result is zero.
REQ-014 sat  output  1  at least one count in the result saturated.
REQ-015 overrun  output  1  sticky; a completed window was discarded because the previous result was still pending.

Function
REQ-016 The FSM SHALL have states IDLE and COUNT; the output holding register SHALL be independent of the FSM.
REQ-017 IDLE -> COUNT on the first cycle with en=1; window is latched and counters cleared in that cycle; the first spike sample is taken on the following cycle.
REQ-018 COUNT SHALL sample spike_in for exactly W cycles (W = latched window, 0 -> 2^WIN_W), incrementing counter i when spike_in[i]=1.
REQ-019 Counters SHALL saturate at 2^CNT_W-1; further spikes in that window SHALL set that window's sat flag.
REQ-020 On the W-th sample cycle the result SHALL include that cycle's spikes; out_valid SHALL rise on the next cycle (latency 1 from the last sample).
REQ-021 In the cycle after the W-th sample, if en=1 then window SHALL be re-latched, counters cleared, and sampling SHALL resume, with no dead cycle between windows.
REQ-022 winner SHALL be the lowest index among the channels with the maximum count, computed before registering; when all counts are 0: winner=0 and winner_valid=0.
REQ-023 counts, winner, winner_valid and sat SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Handshake: out_valid SHALL fall in the cycle after out_valid&out_ready, unless a new result loads in that same cycle, in which case out_valid stays 1 with the new data.
REQ-025 If a window completes while out_valid=1 and out_ready=0, the new result SHALL be discarded and overrun set; overrun SHALL clear only on rst.
REQ-026 en=0 in COUNT SHALL abort: go to IDLE next cycle, clear counters, produce no result; a pending result SHALL be unaffected.
REQ-027 Changes to window during COUNT SHALL NOT affect the current window.

Reset
REQ-028 rst SHALL force IDLE, counters=0, out_valid=0, counts=0, winner=0, winner_valid=0, sat=0, overrun=0.
REQ-029 rst SHALL take priority over en, out_ready and window completion in the same cycle, including mid-window.

Structure
REQ-030 Shared package snn_pkg SHALL hold N_CH, CNT_W and WIN_W defaults and the decoder state enum (IDLE, COUNT).
REQ-031 One sub-module, spike_counter (CNT_W-bit saturating counter with clear, increment and sat outputs), SHALL be instantiated N_CH times.

Verification
REQ-032 window=4, en=1, spike_in=8'h01 for 4 cycles -> counts ch0=4, others 0, winner=0, winner_valid=1, out_valid 1 cycle after the 4th sample.
REQ-033 window=0, spike_in=8'hFF for all 256 cycles -> every count=255, sat=1, winner=0.
REQ-034 window=5, ch3 and ch6 each spike 3 times, ch1 once -> winner=3 (tie resolves to the lower index), ch1 count=1.
REQ-035 window=2, out_ready=0 across two windows -> first result held stable, second discarded, overrun=1; out_ready=1 then releases the first result.
REQ-036 window=8, en dropped on sample 5 -> no out_valid; en raised again -> fresh window counts from 0.
REQ-037 rst asserted on sample 3 of a 4-cycle window with a result pending -> all outputs 0 on the next cycle, no result emitted.
